// File: rtl/i2c_bit_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_bit_sequencer
//
// Bit-level sequencer for the I2C controller. Each command (START, STOP,
// WRITE-bit, READ-bit) is played out as four quarter-SCL-period phases
// A..D, driving the open-drain enables of SCL and SDA. SDA is sampled at
// the end of phase C. SCL clock stretching is honoured in phase B, and a
// WRITE of 1 that reads back 0 is reported as lost arbitration.
//
// Ports
//   controlClock  system clock, all state on the rising edge
//   reset         asynchronous, active-high reset
//   cmd_valid/cmd_ready   command handshake (accepted when both are high)
//   cmd_op        00 START, 01 STOP, 10 WRITE, 11 READ
//   cmd_bit       data bit for WRITE, ignored otherwise
//   scl_in/sda_in raw pad levels (asynchronous, synchronised here)
//   scl_oe/sda_oe 1 = pull the line low, 0 = release it
//   rsp_valid     one-cycle pulse when a command completes
//   rsp_bit       SDA level sampled at the end of phase C
//   arb_lost      qualifies rsp_valid: WRITE aborted on arbitration loss
//   busy          high from the cycle after accept until back in IDLE
// -----------------------------------------------------------------------------
module i2c_bit_sequencer #(
    parameter int unsigned QUARTER_DIV = 250,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       controlClock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_bit,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       rsp_valid,
    output logic       rsp_bit,
    output logic       arb_lost,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_e;

    localparam logic [1:0]       OP_START = 2'b00;
    localparam logic [1:0]       OP_STOP  = 2'b01;
    localparam logic [1:0]       OP_WRITE = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUARTER_DIV - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q;
    logic             bit_q;
    logic             scl_meta_q, scl_s_q, sda_meta_q, sda_s_q;
    logic             scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_bit_q, rsp_bit_d;
    logic             arb_lost_q, arb_lost_d;

    logic             accept, phase_end, stretch_hold, sample_pt, arb_event, done;
    logic [1:0]       op_n;
    logic             bit_n, wr_low;

    assign cmd_ready    = (state_q == IDLE) && !reset;
    assign accept       = cmd_valid && cmd_ready;
    assign phase_end    = (cnt_q == CNT_LAST);
    // A slave holding SCL low in phase B freezes the quarter count; START
    // never waits because it does not depend on the slave's clock.
    assign stretch_hold = (state_q == PH_B) && (op_q != OP_START) && !scl_s_q;
    assign sample_pt    = (state_q == PH_C) && phase_end;
    assign arb_event    = sample_pt && (op_q == OP_WRITE) && bit_q && !sda_s_q;
    assign done         = ((state_q == PH_D) && phase_end) || arb_event;

    // State register: FSM, counter, synchronisers and registered outputs.
    always_ff @(posedge controlClock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            scl_meta_q  <= 1'b1;
            scl_s_q     <= 1'b1;
            sda_meta_q  <= 1'b1;
            sda_s_q     <= 1'b1;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            arb_lost_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scl_meta_q  <= scl_in;
            scl_s_q     <= scl_meta_q;
            sda_meta_q  <= sda_in;
            sda_s_q     <= sda_meta_q;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= rsp_bit_d;
            arb_lost_q  <= arb_lost_d;
        end
    end

    // Command latch: op and bit are frozen for the whole command.
    always_ff @(posedge controlClock or posedge reset) begin
        if (reset) begin
            op_q  <= OP_START;
            bit_q <= 1'b0;
        end else if (accept) begin
            op_q  <= cmd_op;
            bit_q <= cmd_bit;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d = PH_A;
                cnt_d   = '0;
            end
        end else if (stretch_hold) begin
            cnt_d = '0;
        end else if (phase_end) begin
            cnt_d = '0;
            case (state_q)
                PH_A:    state_d = PH_B;
                PH_B:    state_d = PH_C;
                PH_C:    state_d = arb_event ? IDLE : PH_D;
                default: state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output logic. Line enables are computed from the phase being entered
    // so the registered value is in effect on the first cycle of that phase.
    always_comb begin
        op_n        = accept ? cmd_op  : op_q;
        bit_n       = accept ? cmd_bit : bit_q;
        wr_low      = (op_n == OP_WRITE) && !bit_n;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        rsp_valid_d = done;
        arb_lost_d  = arb_event;
        rsp_bit_d   = sample_pt ? sda_s_q : rsp_bit_q;
        if (arb_event) begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_d)
                PH_A: case (op_n)
                    OP_START: {scl_oe_d, sda_oe_d} = 2'b00;
                    OP_STOP:  {scl_oe_d, sda_oe_d} = 2'b11;
                    default:  {scl_oe_d, sda_oe_d} = {1'b1, wr_low};
                endcase
                PH_B: case (op_n)
                    OP_START: {scl_oe_d, sda_oe_d} = 2'b00;
                    OP_STOP:  {scl_oe_d, sda_oe_d} = 2'b01;
                    default:  {scl_oe_d, sda_oe_d} = {1'b0, wr_low};
                endcase
                PH_C: case (op_n)
                    OP_START: {scl_oe_d, sda_oe_d} = 2'b01;
                    OP_STOP:  {scl_oe_d, sda_oe_d} = 2'b01;
                    default:  {scl_oe_d, sda_oe_d} = {1'b0, wr_low};
                endcase
                PH_D: case (op_n)
                    OP_START: {scl_oe_d, sda_oe_d} = 2'b11;
                    OP_STOP:  {scl_oe_d, sda_oe_d} = 2'b00;
                    default:  {scl_oe_d, sda_oe_d} = {1'b1, wr_low};
                endcase
                default: ; // IDLE keeps the last phase-D drive
            endcase
        end
    end

    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_bit   = rsp_bit_q;
    assign arb_lost  = arb_lost_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_bit_sequencer
//
// Directed bench for i2c_bit_sequencer with QUARTER_DIV=4. A table of
// commands with hand-computed per-phase line drive, response bit and
// latency is played through one task; reset and the handshake queue are
// hand-written sequences. All DUT outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_i2c_bit_sequencer;

    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_bit;
    logic       scl_in, sda_in;
    logic       scl_oe, sda_oe;
    logic       rsp_valid, rsp_bit, arb_lost, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2c_bit_sequencer #(.QUARTER_DIV(QD), .CNT_W(16)) dut (
        .controlClock (clk),
        .reset        (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_bit      (cmd_bit),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .scl_oe       (scl_oe),
        .sda_oe       (sda_oe),
        .rsp_valid    (rsp_valid),
        .rsp_bit      (rsp_bit),
        .arb_lost     (arb_lost),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // exp_sda/exp_scl: bit p is the enable in phase p (0=A .. 3=D), 1 = pulled low.
    // ext: hand-computed extra phase-B cycles caused by stretching.
    typedef struct {
        logic [1:0] op;
        logic       b;
        logic       sda_lvl;
        int         stretch;
        int         ext;
        logic [3:0] exp_sda;
        logic [3:0] exp_scl;
        logic       exp_rbit;
        logic       exp_arb;
        int         exp_lat;
    } vec_t;

    vec_t vecs[9];

    // Plays one command; inputs change and outputs are checked on falling edges.
    task automatic run_cmd(input vec_t v, input int idx);
        int         ph;
        logic [4:0] exp5;
        logic [4:0] act5;
        sda_in    = v.sda_lvl;
        scl_in    = 1'b1;
        cmd_op    = v.op;
        cmd_bit   = v.b;
        cmd_valid = 1'b1;
        check($sformatf("v%0d_ready", idx), {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= v.exp_lat; c++) begin
            act5 = {busy, cmd_ready, rsp_valid, scl_oe, sda_oe};
            if (c < v.exp_lat) begin
                if (c <= QD)                ph = 0;
                else if (c <= 2*QD + v.ext) ph = 1;
                else if (c <= 3*QD + v.ext) ph = 2;
                else                        ph = 3;
                exp5 = {3'b100, v.exp_scl[ph], v.exp_sda[ph]};
            end else if (v.exp_arb) begin
                exp5 = 5'b01100;
            end else begin
                exp5 = {3'b011, v.exp_scl[3], v.exp_sda[3]};
            end
            check($sformatf("v%0d_c%0d", idx, c), {27'd0, act5}, {27'd0, exp5});
            if (c == v.exp_lat)
                check($sformatf("v%0d_rsp", idx), {30'd0, rsp_bit, arb_lost},
                      {30'd0, v.exp_rbit, v.exp_arb});
            // Stretch: SCL held low by the bench from cycle 1 for v.stretch cycles of phase B.
            if (v.stretch > 0 && c == 1)                 scl_in = 1'b0;
            if (v.stretch > 0 && c == QD + 1 + v.stretch) scl_in = 1'b1;
            // Junk command presented while busy must be ignored.
            if (c < v.exp_lat - 1) begin
                cmd_valid = 1'b1;
                cmd_op    = ~v.op;
                cmd_bit   = ~v.b;
            end else begin
                cmd_valid = 1'b0;
            end
            if (c < v.exp_lat) @(negedge clk);
        end
        // One cycle later: pulse gone, lines hold their final drive.
        @(negedge clk);
        exp5 = v.exp_arb ? 5'b01000 : {3'b010, v.exp_scl[3], v.exp_sda[3]};
        check($sformatf("v%0d_hold", idx), {27'd0, busy, cmd_ready, rsp_valid, scl_oe, sda_oe},
              {27'd0, exp5});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] hs_op [3];
        logic       hs_b  [3];
        int         acc_cyc [3];
        int         n_acc, n_rsp, cyc;
        logic       saw_rsp;

        //            op     b     sda   st  ext  sda      scl      rb    arb   lat
        vecs[0] = '{2'b00, 1'b0, 1'b1, 0,  0,  4'b1100, 4'b1000, 1'b1, 1'b0, 17}; // START
        vecs[1] = '{2'b10, 1'b0, 1'b0, 0,  0,  4'b1111, 4'b1001, 1'b0, 1'b0, 17}; // WRITE 0
        vecs[2] = '{2'b01, 1'b0, 1'b1, 0,  0,  4'b0111, 4'b0001, 1'b1, 1'b0, 17}; // STOP
        vecs[3] = '{2'b11, 1'b1, 1'b1, 0,  0,  4'b0000, 4'b1001, 1'b1, 1'b0, 17}; // READ sda=1
        vecs[4] = '{2'b11, 1'b0, 1'b0, 0,  0,  4'b0000, 4'b1001, 1'b0, 1'b0, 17}; // READ sda=0
        vecs[5] = '{2'b10, 1'b1, 1'b1, 10, 12, 4'b0000, 4'b1001, 1'b1, 1'b0, 29}; // WRITE 1 stretched
        vecs[6] = '{2'b10, 1'b1, 1'b0, 0,  0,  4'b0000, 4'b1001, 1'b0, 1'b1, 13}; // WRITE 1 arb lost
        vecs[7] = '{2'b00, 1'b1, 1'b1, 10, 0,  4'b1100, 4'b1000, 1'b1, 1'b0, 17}; // START ignores stretch
        vecs[8] = '{2'b10, 1'b0, 1'b1, 0,  0,  4'b1111, 4'b1001, 1'b1, 1'b0, 17}; // WRITE 0, sda seen high

        // Reset state.
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_bit   = 1'b0;
        scl_in    = 1'b1;
        sda_in    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {25'd0, cmd_ready, busy, rsp_valid, rsp_bit, arb_lost, scl_oe, sda_oe},
              32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {30'd0, cmd_ready, busy}, 32'b10);

        // Reset in the middle of a WRITE 0.
        cmd_op    = 2'b10;
        cmd_bit   = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midcmd_phase_a", {29'd0, busy, scl_oe, sda_oe}, 32'b111);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midcmd_async_release", {29'd0, scl_oe, sda_oe, cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midcmd_ready", {30'd0, cmd_ready, busy}, 32'b10);
        saw_rsp = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) saw_rsp = 1'b1;
            @(negedge clk);
        end
        check("midcmd_no_rsp", {31'd0, saw_rsp}, 32'd0);

        // Table-driven commands.
        for (int i = 0; i < 9; i++) run_cmd(vecs[i], i);

        // Handshake: three commands queued behind a constantly valid request.
        hs_op[0] = 2'b10; hs_b[0] = 1'b1;
        hs_op[1] = 2'b11; hs_b[1] = 1'b0;
        hs_op[2] = 2'b10; hs_b[2] = 1'b0;
        sda_in = 1'b1;
        scl_in = 1'b1;
        n_acc  = 0;
        n_rsp  = 0;
        cyc    = 0;
        for (int k = 0; k < 100 && n_rsp < 3; k++) begin
            if (rsp_valid) begin
                if (n_rsp < n_acc)
                    check($sformatf("hs_lat%0d", n_rsp), cyc - acc_cyc[n_rsp], 17);
                check($sformatf("hs_rsp%0d", n_rsp), {30'd0, rsp_bit, arb_lost}, 32'b10);
                n_rsp++;
            end
            if (n_acc < 3) begin
                cmd_valid = 1'b1;
                cmd_op    = hs_op[n_acc];
                cmd_bit   = hs_b[n_acc];
                if (cmd_ready) begin
                    acc_cyc[n_acc] = cyc;
                    if (n_acc > 0)
                        check($sformatf("hs_gap%0d", n_acc), cyc - acc_cyc[n_acc-1], 17);
                    n_acc++;
                end
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        check("hs_accepts", n_acc, 3);
        check("hs_responses", n_rsp, 3);
        repeat (20) @(negedge clk);
        check("hs_no_extra", {30'd0, busy, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
